// File: rtl/memory_avmm_pkg.sv
// Shared types for the Avalon-MM read responder: FSM state encoding and queued command format.
package memory_avmm_pkg;

  localparam int AVMM_ADDR_W  = 30;
  localparam int AVMM_BURST_W = 2;

  typedef enum bit [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } e_state;

  typedef struct packed {
    logic [AVMM_ADDR_W-1:0]  addr;
    logic [AVMM_BURST_W-1:0] burstcount;
  } t_avmm_cmd;

  // A burstcount of zero is served as a single word.
  function automatic logic [AVMM_BURST_W-1:0] norm_burst(input logic [AVMM_BURST_W-1:0] bc);
    return (bc == '0) ? AVMM_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/memory_avmm_responder_cmd_fifo.sv
// Synchronous command queue for the read responder; power-of-2 depth, pointers wrap naturally.
module avmm_cmd_fifo
  import memory_avmm_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  t_avmm_cmd        push_data,
  input  logic             pop,
  output t_avmm_cmd        pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  t_avmm_cmd        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_avmm_responder.sv
// Avalon-MM pipelined read responder fetching one word at a time from a request/ack backing store.
// MEMORY_AVMM_OOR_EN: words at or above MEM_WORDS are answered with zero without touching the store.
//
// state   | meaning
// S_IDLE  | no active command; pops the queue when it holds one
// S_FETCH | serving the current command, one backing-store access at a time
module memory_avmm_responder
  import memory_avmm_pkg::*;
#(
  parameter int ADDR_W    = AVMM_ADDR_W,
  parameter int BURST_W   = AVMM_BURST_W,
  parameter int CMD_DEPTH = 2,
  parameter int MEM_WORDS = 23040
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avmm_data_addr,
  input  logic              avmm_data_read,
  input  logic [BURST_W-1:0] avmm_data_burstcount,
  output logic              avmm_data_waitrequest,
  output logic [31:0]       avmm_data_readdata,
  output logic              avmm_data_readdatavalid,
  output logic              mem_request,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

  e_state             state;
  e_state             state_nxt;
  logic               rst_done;
  logic [ADDR_W-1:0]  cur_addr;
  logic [BURST_W-1:0] remaining;
  logic               req_gap;
  logic               oor;
  logic               word_done;
  logic               load;
  logic               advance;
  logic               cmd_pop;
  logic               cmd_push;
  logic               accept;
  t_avmm_cmd          cmd_in;
  t_avmm_cmd          cmd_out;
  logic [CNT_W-1:0]   cmd_count;
  logic               cmd_full;
  logic               cmd_empty;

  // Held high through reset and released by the first clock edge after it.
  assign avmm_data_waitrequest = !rst_done || (cmd_count == CNT_W'(CMD_DEPTH));
  assign accept   = avmm_data_read && !avmm_data_waitrequest;
  assign cmd_push = accept && !cmd_full;

  assign cmd_in.addr       = avmm_data_addr;
  assign cmd_in.burstcount = norm_burst(avmm_data_burstcount);

  avmm_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_out),
    .count     (cmd_count),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

`ifdef MEMORY_AVMM_OOR_EN
  assign oor = (cur_addr >= ADDR_W'(MEM_WORDS));
`else
  logic unused_mem_words;
  assign unused_mem_words = ^ADDR_W'(MEM_WORDS);
  assign oor = 1'b0;
`endif

  // req_gap forces the request low for one cycle after every ack.
  assign mem_request = (state == S_FETCH) && !req_gap && !oor;
  assign mem_address = cur_addr;
  assign word_done   = (state == S_FETCH) && (oor || (mem_request && mem_ack));

  always_comb begin
    state_nxt = state;
    cmd_pop   = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop   = 1'b1;
          load      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (word_done) begin
          advance = 1'b1;
          if (remaining == BURST_W'(1)) begin
            if (!cmd_empty) begin
              cmd_pop = 1'b1;
              load    = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= S_IDLE;
      rst_done                <= 1'b0;
      cur_addr                <= '0;
      remaining               <= '0;
      req_gap                 <= 1'b0;
      avmm_data_readdata      <= '0;
      avmm_data_readdatavalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      req_gap  <= mem_request && mem_ack;
      if (load) begin
        cur_addr  <= cmd_out.addr;
        remaining <= cmd_out.burstcount;
      end else if (advance) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - BURST_W'(1);
      end
      avmm_data_readdatavalid <= word_done;
      if (word_done) avmm_data_readdata <= oor ? 32'h0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_avmm_responder.sv
// Directed bench for memory_avmm_responder with a latency-programmable backing-store model.
module tb_memory_avmm_responder;

  logic        clock;
  logic        reset_n;
  logic [29:0] avmm_data_addr;
  logic        avmm_data_read;
  logic [1:0]  avmm_data_burstcount;
  logic        avmm_data_waitrequest;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_readdatavalid;
  logic        mem_request;
  logic [29:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_lat = 0;
  logic mem_hold = 1'b0;
  int lat_cnt = 0;
  int ack_cyc = 0;
  logic [31:0] rsp_q[$];
  int          vld_cyc[$];
  logic [29:0] addr_q[$];

  memory_avmm_responder dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .avmm_data_addr          (avmm_data_addr),
    .avmm_data_read          (avmm_data_read),
    .avmm_data_burstcount    (avmm_data_burstcount),
    .avmm_data_waitrequest   (avmm_data_waitrequest),
    .avmm_data_readdata      (avmm_data_readdata),
    .avmm_data_readdatavalid (avmm_data_readdatavalid),
    .mem_request             (mem_request),
    .mem_address             (mem_address),
    .mem_ack                 (mem_ack),
    .mem_rdata               (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Backing store: word at address a reads as 0xD0000000 | a.
  always @(negedge clock) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_request && !mem_hold) begin
      if (lat_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hD000_0000 | {2'b00, mem_address};
        addr_q.push_back(mem_address);
        ack_cyc   = cyc;
        lat_cnt   = 0;
      end else begin
        lat_cnt++;
      end
    end else if (!mem_request) begin
      lat_cnt = 0;
    end
  end

  always @(negedge clock) begin
    if (avmm_data_readdatavalid) begin
      rsp_q.push_back(avmm_data_readdata);
      vld_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    vld_cyc.delete();
    addr_q.delete();
  endtask

  task automatic issue(input logic [29:0] a, input logic [1:0] bc, input string tag);
    int n = 0;
    @(negedge clock);
    avmm_data_addr       = a;
    avmm_data_burstcount = bc;
    avmm_data_read       = 1'b1;
    while (avmm_data_waitrequest !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
    @(negedge clock);
    avmm_data_read = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_q.size() < n && k < 300) begin
      @(negedge clock);
      #1;
      k++;
    end
    check(tag, 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n              = 1'b0;
    avmm_data_addr       = '0;
    avmm_data_read       = 1'b0;
    avmm_data_burstcount = '0;
    mem_ack              = 1'b0;
    mem_rdata            = '0;

    // Reset state
    #12;
    check("rst_waitrequest", 32'(avmm_data_waitrequest), 32'd1);
    check("rst_rdv", 32'(avmm_data_readdatavalid), 32'd0);
    check("rst_readdata", avmm_data_readdata, 32'h0);
    check("rst_mem_request", 32'(mem_request), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("wr_after_reset", 32'(avmm_data_waitrequest), 32'd0);

    // 1: single read, ack three cycles after request
    clear_logs();
    mem_lat = 3;
    issue(30'h10, 2'd1, "t1_accept");
    wait_rsp(1, "t1_count");
    check("t1_data", rsp_q[0], 32'hD000_0010);
    check("t1_addr", 32'(addr_q[0]), 32'h10);
    check("t1_latency", 32'(vld_cyc[0]), 32'(ack_cyc + 1));
    settle(4);
    check("t1_no_extra", 32'(rsp_q.size()), 32'd1);

    // 2: burst of three, ascending addresses
    clear_logs();
    mem_lat = 1;
    issue(30'h20, 2'd3, "t2_accept");
    wait_rsp(3, "t2_count");
    check("t2_d0", rsp_q[0], 32'hD000_0020);
    check("t2_d1", rsp_q[1], 32'hD000_0021);
    check("t2_d2", rsp_q[2], 32'hD000_0022);
    check("t2_a2", 32'(addr_q[2]), 32'h22);

    // 3: back-to-back commands with the store stalled until the queue backs up
    clear_logs();
    mem_lat  = 0;
    mem_hold = 1'b1;
    issue(30'h40, 2'd2, "t3_acc_a");
    issue(30'h50, 2'd1, "t3_acc_b");
    issue(30'h60, 2'd1, "t3_acc_c");
    @(negedge clock);
    avmm_data_addr       = 30'h70;
    avmm_data_burstcount = 2'd0;
    avmm_data_read       = 1'b1;
    #1;
    check("t3_wr_full", 32'(avmm_data_waitrequest), 32'd1);
    settle(4);
    check("t3_wr_held", 32'(avmm_data_waitrequest), 32'd1);
    check("t3_no_rsp", 32'(rsp_q.size()), 32'd0);
    mem_hold = 1'b0;
    begin
      int n = 0;
      while (avmm_data_waitrequest !== 1'b0 && n < 200) begin
        @(negedge clock);
        n++;
      end
      check("t3_acc_d", 32'(n < 200), 32'd1);
    end
    @(negedge clock);
    avmm_data_read = 1'b0;
    wait_rsp(5, "t3_count");
    check("t3_r0", rsp_q[0], 32'hD000_0040);
    check("t3_r1", rsp_q[1], 32'hD000_0041);
    check("t3_r2", rsp_q[2], 32'hD000_0050);
    check("t3_r3", rsp_q[3], 32'hD000_0060);
    check("t3_r4_bc0", rsp_q[4], 32'hD000_0070);
    settle(4);
    check("t3_no_extra", 32'(rsp_q.size()), 32'd5);

    // 4: address wrap at the top of the word space
    clear_logs();
    mem_lat = 0;
    issue(30'h3FFF_FFFF, 2'd2, "t4_accept");
    wait_rsp(2, "t4_count");
`ifdef MEMORY_AVMM_OOR_EN
    check("t4_d0", rsp_q[0], 32'h0);
    check("t4_d1", rsp_q[1], 32'hD000_0000);
    check("t4_naddr", 32'(addr_q.size()), 32'd1);
    check("t4_a0", 32'(addr_q[0]), 32'h0);
`else
    check("t4_d0", rsp_q[0], 32'hFFFF_FFFF);
    check("t4_d1", rsp_q[1], 32'hD000_0000);
    check("t4_a0", 32'(addr_q[0]), 32'h3FFF_FFFF);
    check("t4_a1", 32'(addr_q[1]), 32'h0);
`endif

    // 5: reset mid-burst after the first word
    clear_logs();
    mem_lat = 1;
    issue(30'h80, 2'd3, "t5_accept");
    wait_rsp(1, "t5_first");
    reset_n = 1'b0;
    #1;
    check("t5_rdv_async", 32'(avmm_data_readdatavalid), 32'd0);
    check("t5_req_async", 32'(mem_request), 32'd0);
    check("t5_wr_in_reset", 32'(avmm_data_waitrequest), 32'd1);
    settle(3);
    check("t5_no_more", 32'(rsp_q.size()), 32'd1);
    check("t5_req_held", 32'(mem_request), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_logs();
    issue(30'h90, 2'd1, "t5_accept2");
    wait_rsp(1, "t5_count2");
    check("t5_d_after", rsp_q[0], 32'hD000_0090);
    settle(6);
    check("t5_no_stale", 32'(rsp_q.size()), 32'd1);

    // 6: burst straddling the end of the valid word range
    clear_logs();
    mem_lat = 0;
    issue(30'h59FF, 2'd2, "t6_accept");
    wait_rsp(2, "t6_count");
    check("t6_d0", rsp_q[0], 32'hD000_59FF);
`ifdef MEMORY_AVMM_OOR_EN
    check("t6_d1", rsp_q[1], 32'h0);
    check("t6_naddr", 32'(addr_q.size()), 32'd1);
`else
    check("t6_d1", rsp_q[1], 32'hD000_5A00);
    check("t6_naddr", 32'(addr_q.size()), 32'd2);
`endif

    settle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
